// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, 8 data bits (LSB first), parity, stop.
// Recovers the byte, checks parity and framing, and pulses rx_done_tick once per frame.
`timescale 1ns/1ps

module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter bit ODD_nEVEN  = 1'b1
) (
    input  logic       UART_clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       rx_done_tick,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shreg;
    logic          r_par_bit;
    logic [7:0]    r_data;
    logic          r_tick;
    logic          r_perr;
    logic          r_ferr;

    state_t        w_state_next;
    logic [CW-1:0] w_cnt_next;
    logic [2:0]    w_bit_idx_next;
    logic [7:0]    w_shreg_next;
    logic          w_par_bit_next;
    logic [7:0]    w_data_next;
    logic          w_tick_next;
    logic          w_perr_next;
    logic          w_ferr_next;
    logic          w_rx_s;
    logic          w_cnt_half;
    logic          w_cnt_full;

    assign w_rx_s     = r_sync2;
    assign w_cnt_half = (r_cnt == CNT_HALF);
    assign w_cnt_full = (r_cnt == CNT_FULL);

    // Two-flop synchroniser; resets to MARK so no false start edge after reset.
    always_ff @(posedge UART_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge UART_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
            r_par_bit <= 1'b0;
            r_data    <= '0;
            r_tick    <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shreg   <= w_shreg_next;
            r_par_bit <= w_par_bit_next;
            r_data    <= w_data_next;
            r_tick    <= w_tick_next;
            r_perr    <= w_perr_next;
            r_ferr    <= w_ferr_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_bit_idx_next = r_bit_idx;
        w_shreg_next   = r_shreg;
        w_par_bit_next = r_par_bit;
        w_data_next    = r_data;
        w_tick_next    = 1'b0;
        w_perr_next    = r_perr;
        w_ferr_next    = r_ferr;

        unique case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (!w_rx_s) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                // Half-bit check re-centres sampling on the middle of each bit.
                if (w_cnt_half) begin
                    w_cnt_next = '0;
                    if (!w_rx_s) begin
                        w_state_next   = S_DATA;
                        w_bit_idx_next = '0;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (w_cnt_full) begin
                    w_cnt_next   = '0;
                    w_shreg_next = {w_rx_s, r_shreg[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_PARITY;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_PARITY: begin
                if (w_cnt_full) begin
                    w_cnt_next     = '0;
                    w_par_bit_next = w_rx_s;
                    w_state_next   = S_STOP;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_STOP: begin
                // Leaving mid stop bit lets a back-to-back start edge be caught.
                if (w_cnt_full) begin
                    w_cnt_next   = '0;
                    w_data_next  = r_shreg;
                    w_tick_next  = 1'b1;
                    w_perr_next  = ODD_nEVEN ? ~^{r_shreg, r_par_bit}
                                             :  ^{r_shreg, r_par_bit};
                    w_ferr_next  = ~w_rx_s;
                    w_state_next = w_rx_s ? S_IDLE : S_BREAK;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_BREAK: begin
                w_cnt_next = '0;
                if (w_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign data_out     = r_data;
    assign rx_done_tick = r_tick;
    assign parity_err   = r_perr;
    assign frame_err    = r_ferr;
    assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: an odd-parity and an even-parity instance,
// expected frames queued when driven and compared when rx_done_tick fires.
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int N = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_odd  = 1'b1;
    logic       rx_even = 1'b1;
    logic [7:0] d_odd, d_even;
    logic       t_odd, t_even, pe_odd, pe_even, fe_odd, fe_even, b_odd, b_even;

    always #5 clk = ~clk;

    uart_rx #(.OVERSAMPLE(N), .ODD_nEVEN(1'b1)) dut_odd (
        .UART_clk    (clk),
        .rst_n       (rst_n),
        .rx          (rx_odd),
        .data_out    (d_odd),
        .rx_done_tick(t_odd),
        .parity_err  (pe_odd),
        .frame_err   (fe_odd),
        .busy        (b_odd)
    );

    uart_rx #(.OVERSAMPLE(N), .ODD_nEVEN(1'b0)) dut_even (
        .UART_clk    (clk),
        .rst_n       (rst_n),
        .rx          (rx_even),
        .data_out    (d_even),
        .rx_done_tick(t_even),
        .parity_err  (pe_even),
        .frame_err   (fe_even),
        .busy        (b_even)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [9:0] q_odd[$];
    logic [9:0] q_even[$];
    logic [9:0] e_odd, e_even;
    int ticks_odd = 0, ticks_even = 0;
    int last_tick_odd = 0, last_tick_even = 0, prev_tick_even = 0;
    logic t_odd_d = 1'b0, t_even_d = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Output monitor: sampled on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (t_odd) begin
                ticks_odd++;
                last_tick_odd = cyc;
                $display("[TB] odd  tick cyc=%0d data=%02h perr=%0b ferr=%0b", cyc, d_odd, pe_odd, fe_odd);
                if (q_odd.size() == 0) begin
                    check("odd_spurious_tick", 1, 0);
                end else begin
                    e_odd = q_odd.pop_front();
                    check("odd_data", d_odd, e_odd[7:0]);
                    check("odd_perr", pe_odd, e_odd[8]);
                    check("odd_ferr", fe_odd, e_odd[9]);
                end
                if (t_odd_d) check("odd_tick_width", 2, 1);
            end
            if (t_even) begin
                ticks_even++;
                prev_tick_even = last_tick_even;
                last_tick_even = cyc;
                $display("[TB] even tick cyc=%0d data=%02h perr=%0b ferr=%0b", cyc, d_even, pe_even, fe_even);
                if (q_even.size() == 0) begin
                    check("even_spurious_tick", 1, 0);
                end else begin
                    e_even = q_even.pop_front();
                    check("even_data", d_even, e_even[7:0]);
                    check("even_perr", pe_even, e_even[8]);
                    check("even_ferr", fe_even, e_even[9]);
                end
                if (t_even_d) check("even_tick_width", 2, 1);
            end
        end
        t_odd_d  = t_odd;
        t_even_d = t_even;
    end

    // Drives one frame at N clocks per bit; k_cyc is the first edge that registers the start bit.
    task automatic send(input bit even, input logic [7:0] data, input logic par,
                        input logic stop, output int k_cyc);
        logic [10:0] bits;
        bits  = {stop, par, data, 1'b0};
        k_cyc = cyc + 1;
        for (int i = 0; i < 11; i++) begin
            if (even) rx_even = bits[i];
            else      rx_odd  = bits[i];
            repeat (N) @(negedge clk);
        end
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        return ~^d;
    endfunction

    initial begin
        int k, k2;
        logic [7:0] partial;

        repeat (3) @(negedge clk);
        check("rst_data", d_odd, 8'h00);
        check("rst_tick", t_odd, 1'b0);
        check("rst_perr", pe_odd, 1'b0);
        check("rst_ferr", fe_odd, 1'b0);
        check("rst_busy", b_odd, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: clean odd-parity frame and latency
        q_odd.push_back({1'b0, 1'b0, 8'hA5});
        send(1'b0, 8'hA5, 1'b1, 1'b1, k);
        check("t1_ticks", ticks_odd, 1);
        check("t1_latency", last_tick_odd - k, 170);
        repeat (N) @(negedge clk);

        // 2: wrong parity bit
        q_odd.push_back({1'b0, 1'b1, 8'h3C});
        send(1'b0, 8'h3C, 1'b0, 1'b1, k);
        check("t2_ticks", ticks_odd, 2);
        repeat (N) @(negedge clk);

        // 3: short glitch rejected in START
        rx_odd = 1'b0;
        repeat (3) @(negedge clk);
        check("t3_busy_hi", b_odd, 1'b1);
        rx_odd = 1'b1;
        repeat (2 * N) @(negedge clk);
        check("t3_busy_lo", b_odd, 1'b0);
        check("t3_ticks", ticks_odd, 2);
        check("t3_data_held", d_odd, 8'h3C);
        check("t3_perr_held", pe_odd, 1'b1);
        check("t3_ferr_held", fe_odd, 1'b0);

        // 4: bad stop bit, line held low (break)
        q_odd.push_back({1'b1, 1'b0, 8'h81});
        send(1'b0, 8'h81, odd_par(8'h81), 1'b0, k);
        repeat (4 * N) @(negedge clk);
        check("t4_busy_break", b_odd, 1'b1);
        check("t4_ticks", ticks_odd, 3);
        check("t4_ferr_held", fe_odd, 1'b1);
        rx_odd = 1'b1;
        repeat (4) @(negedge clk);
        check("t4_busy_lo", b_odd, 1'b0);
        repeat (N) @(negedge clk);

        // 5: reset during data bit 4, then a clean frame
        partial = 8'h77;
        rx_odd = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_odd = partial[i];
            repeat (N) @(negedge clk);
        end
        rx_odd = partial[4];
        repeat (N / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_rst_data", d_odd, 8'h00);
        check("t5_rst_tick", t_odd, 1'b0);
        check("t5_rst_perr", pe_odd, 1'b0);
        check("t5_rst_ferr", fe_odd, 1'b0);
        check("t5_rst_busy", b_odd, 1'b0);
        @(negedge clk);
        rx_odd = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * N) @(negedge clk);
        check("t5_no_tick", ticks_odd, 3);
        q_odd.push_back({1'b0, 1'b0, 8'h5A});
        send(1'b0, 8'h5A, odd_par(8'h5A), 1'b1, k);
        check("t5_ticks", ticks_odd, 4);
        check("t5_data", d_odd, 8'h5A);
        repeat (N) @(negedge clk);

        // 6: even parity, back-to-back frames with no idle gap
        q_even.push_back({1'b0, 1'b0, 8'h00});
        q_even.push_back({1'b0, 1'b0, 8'hFF});
        send(1'b1, 8'h00, ^(8'h00), 1'b1, k);
        send(1'b1, 8'hFF, ^(8'hFF), 1'b1, k2);
        repeat (N) @(negedge clk);
        check("t6_ticks", ticks_even, 2);
        check("t6_spacing", last_tick_even - prev_tick_even, 11 * N);
        check("t6_data_last", d_even, 8'hFF);
        check("t6_busy_lo", b_even, 1'b0);

        check("sb_odd_empty", q_odd.size(), 0);
        check("sb_even_empty", q_even.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
